codec_i2s_port: RTL and testbench

CODEC_I2S_PORT -- requirements
Module: codec_i2s_port

---
 rtl/codec_i2s_port.sv | 232 +++++++++++++++++++++++
 tb/tb_codec_i2s_port.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2s_port.sv
// I2S codec port: captures ADC stereo frames into a read FIFO and plays
// DAC stereo pairs from a write FIFO. Codec pins are asynchronous to ck.
module codec_i2s_port #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          bclk,
  input  logic          adclrck,
  input  logic          daclrck,
  input  logic          adcdat,
  output logic          dacdat,
  input  logic          read,
  output logic          read_ready,
  output logic [DW-1:0] readdata_left,
  output logic [DW-1:0] readdata_right,
  input  logic          write,
  output logic          write_ready,
  input  logic [DW-1:0] writedata_left,
  input  logic [DW-1:0] writedata_right,
  output logic          adc_overflow,
  output logic          dac_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DW + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DW + 1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] MSB_ONE  = {1'b1, {(DW-1){1'b0}}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_SAT) ? v : v + CW'(1);
  endfunction

  // Pin synchronizers; bit order {adcdat, daclrck, adclrck, bclk}
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [2:0] r_sync3;
  logic       w_bclk_rise;
  logic       w_bclk_fall;
  logic       w_alr_edge;
  logic       w_dlr_rise;
  logic       w_dlr_fall;
  logic       w_adcdat;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= {adcdat, daclrck, adclrck, bclk};
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2[2:0];
    end
  end

  assign w_bclk_rise = r_sync2[0] & ~r_sync3[0];
  assign w_bclk_fall = ~r_sync2[0] & r_sync3[0];
  assign w_alr_edge  = r_sync2[1] ^ r_sync3[1];
  assign w_dlr_rise  = r_sync2[2] & ~r_sync3[2];
  assign w_dlr_fall  = ~r_sync2[2] & r_sync3[2];
  assign w_adcdat    = r_sync2[3];

  // ADC capture: a walking mask places each bit, so short words keep zero LSBs
  logic [CW-1:0] r_adc_cnt;
  logic          r_adc_ch;
  logic          r_adc_armed;
  logic          r_adc_pend;
  logic [DW-1:0] r_adc_mask;
  logic [DW-1:0] r_adc_left;
  logic [DW-1:0] r_adc_right;
  logic          w_adc_cap;
  logic [DW-1:0] w_adc_bit;

  assign w_adc_cap = r_adc_armed && w_bclk_rise && (r_adc_cnt != '0) && (r_adc_cnt <= CNT_LAST);
  assign w_adc_bit = r_adc_mask & {DW{w_adcdat}};

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_adc_cnt   <= '0;
      r_adc_ch    <= 1'b0;
      r_adc_armed <= 1'b0;
      r_adc_pend  <= 1'b0;
      r_adc_mask  <= '0;
      r_adc_left  <= '0;
      r_adc_right <= '0;
    end else begin
      r_adc_pend <= 1'b0;
      if (w_alr_edge) begin
        r_adc_armed <= 1'b1;
        r_adc_cnt   <= '0;
        r_adc_ch    <= r_sync2[1];
        r_adc_mask  <= MSB_ONE;
        if (r_sync2[1]) r_adc_right <= '0;
        else            r_adc_left  <= '0;
      end else if (r_adc_armed && w_bclk_rise) begin
        r_adc_cnt <= sat_inc(r_adc_cnt);
        if (w_adc_cap) begin
          r_adc_mask <= r_adc_mask >> 1;
          if (r_adc_ch) r_adc_right <= r_adc_right | w_adc_bit;
          else          r_adc_left  <= r_adc_left | w_adc_bit;
          if (r_adc_ch && (r_adc_cnt == CNT_LAST)) r_adc_pend <= 1'b1;
        end
      end
    end
  end

  // ADC FIFO: a push into a full FIFO still lands if a pop frees the slot
  logic [DW-1:0] r_afifo_l [DEPTH];
  logic [DW-1:0] r_afifo_r [DEPTH];
  logic [AW-1:0] r_af_wp;
  logic [AW-1:0] r_af_rp;
  logic [AW:0]   r_af_occ;
  logic          r_adc_ovf;
  logic          w_af_full;
  logic          w_af_pop;
  logic          w_af_push;

  assign w_af_full  = (r_af_occ == OCC_FULL);
  assign read_ready = (r_af_occ != '0);
  assign w_af_pop   = read && read_ready;
  assign w_af_push  = r_adc_pend && (!w_af_full || w_af_pop);

  assign readdata_left  = read_ready ? r_afifo_l[r_af_rp] : '0;
  assign readdata_right = read_ready ? r_afifo_r[r_af_rp] : '0;
  assign adc_overflow   = r_adc_ovf;

  always_ff @(posedge ck) begin
    if (w_af_push) begin
      r_afifo_l[r_af_wp] <= r_adc_left;
      r_afifo_r[r_af_wp] <= r_adc_right;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_af_wp   <= '0;
      r_af_rp   <= '0;
      r_af_occ  <= '0;
      r_adc_ovf <= 1'b0;
    end else begin
      if (w_af_push) r_af_wp <= r_af_wp + AW'(1);
      if (w_af_pop)  r_af_rp <= r_af_rp + AW'(1);
      case ({w_af_push, w_af_pop})
        2'b10:   r_af_occ <= r_af_occ + (AW+1)'(1);
        2'b01:   r_af_occ <= r_af_occ - (AW+1)'(1);
        default: r_af_occ <= r_af_occ;
      endcase
      if (r_adc_pend && !w_af_push) r_adc_ovf <= 1'b1;
    end
  end

  // DAC FIFO, popped once per frame at the left-channel start
  logic [DW-1:0] r_dfifo_l [DEPTH];
  logic [DW-1:0] r_dfifo_r [DEPTH];
  logic [AW-1:0] r_df_wp;
  logic [AW-1:0] r_df_rp;
  logic [AW:0]   r_df_occ;
  logic          r_wr_en;
  logic          w_df_empty;
  logic          w_df_push;
  logic          w_df_pop;

  assign w_df_empty  = (r_df_occ == '0);
  assign write_ready = r_wr_en && (r_df_occ != OCC_FULL);
  assign w_df_push   = write && write_ready;
  assign w_df_pop    = w_dlr_fall && !w_df_empty;

  always_ff @(posedge ck) begin
    if (w_df_push) begin
      r_dfifo_l[r_df_wp] <= writedata_left;
      r_dfifo_r[r_df_wp] <= writedata_right;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_df_wp  <= '0;
      r_df_rp  <= '0;
      r_df_occ <= '0;
      r_wr_en  <= 1'b0;
    end else begin
      r_wr_en <= 1'b1;
      if (w_df_push) r_df_wp <= r_df_wp + AW'(1);
      if (w_df_pop)  r_df_rp <= r_df_rp + AW'(1);
      case ({w_df_push, w_df_pop})
        2'b10:   r_df_occ <= r_df_occ + (AW+1)'(1);
        2'b01:   r_df_occ <= r_df_occ - (AW+1)'(1);
        default: r_df_occ <= r_df_occ;
      endcase
    end
  end

  // DAC serializer: the bclk fall that coincides with an LRCK edge emits the
  // old MSB, so the new word's MSB leaves one bclk after the transition
  logic [DW-1:0] r_dac_sh;
  logic [DW-1:0] r_dac_rhold;
  logic          r_dacdat;
  logic          r_dac_unf;

  assign dacdat        = r_dacdat;
  assign dac_underflow = r_dac_unf;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_dac_sh    <= '0;
      r_dac_rhold <= '0;
      r_dacdat    <= 1'b0;
      r_dac_unf   <= 1'b0;
    end else begin
      if (w_bclk_fall) r_dacdat <= r_dac_sh[DW-1];
      if (w_dlr_fall) begin
        if (w_df_empty) begin
          r_dac_sh    <= '0;
          r_dac_rhold <= '0;
          r_dac_unf   <= 1'b1;
        end else begin
          r_dac_sh    <= r_dfifo_l[r_df_rp];
          r_dac_rhold <= r_dfifo_r[r_df_rp];
        end
      end else if (w_dlr_rise) begin
        r_dac_sh <= r_dac_rhold;
      end else if (w_bclk_fall) begin
        r_dac_sh <= {r_dac_sh[DW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_codec_i2s_port.sv
// Bench for codec_i2s_port: directed I2S frames, expected ADC pairs and DAC
// words queued at stimulus time and consumed by independent monitors.
module tb_codec_i2s_port;
  localparam int DW   = 24;
  localparam int HB   = 80;
  localparam int SLOT = 32;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b1;
  logic          adclrck = 1'b1;
  logic          daclrck = 1'b1;
  logic          adcdat = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] wl = '0;
  logic [DW-1:0] wr = '0;
  logic          dacdat;
  logic          read_ready;
  logic          write_ready;
  logic          adc_overflow;
  logic          dac_underflow;
  logic [DW-1:0] rdl;
  logic [DW-1:0] rdr;

  int checks = 0;
  int errors = 0;
  logic [2*DW-1:0] adc_exp[$];
  logic [DW-1:0]   dac_exp[$];
  bit              dac_chk = 1'b0;

  logic [DW-1:0] tl [5] = '{24'h800001, 24'h7FFFFE, 24'hFFFFFF, 24'h000000, 24'h5A5A5A};
  logic [DW-1:0] tr [5] = '{24'h000001, 24'hFFFFFF, 24'h800000, 24'h3C3C3C, 24'h0F0F0F};

  codec_i2s_port #(.DW(DW), .DEPTH(4)) dut (
    .ck(ck), .rst(rst), .bclk(bclk), .adclrck(adclrck), .daclrck(daclrck),
    .adcdat(adcdat), .dacdat(dacdat), .read(read), .read_ready(read_ready),
    .readdata_left(rdl), .readdata_right(rdr), .write(write),
    .write_ready(write_ready), .writedata_left(wl), .writedata_right(wr),
    .adc_overflow(adc_overflow), .dac_underflow(dac_underflow)
  );

  always #5 ck = ~ck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_ready"}, read_ready, 0);
    check({tag, "_write_ready"}, write_ready, 0);
    check({tag, "_readdata_left"}, rdl, 0);
    check({tag, "_readdata_right"}, rdr, 0);
    check({tag, "_dacdat"}, dacdat, 0);
    check({tag, "_adc_overflow"}, adc_overflow, 0);
    check({tag, "_dac_underflow"}, dac_underflow, 0);
  endtask

  // ADC monitor: every accepted pop is compared against the queued pair
  always @(negedge ck) begin
    if (read && read_ready) begin
      if (adc_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL adc_pop: got %h_%h, expected no data", rdl, rdr);
      end else begin
        logic [2*DW-1:0] e;
        e = adc_exp.pop_front();
        check("adc_left", rdl, e[2*DW-1:DW]);
        check("adc_right", rdr, e[DW-1:0]);
      end
    end
  end

  // DAC monitor: receiver view, sampling dacdat on bclk rising edges
  int          m_idx = 100;
  logic        m_prev = 1'b1;
  logic [DW-1:0] m_word = '0;
  always @(posedge bclk) begin
    if (daclrck != m_prev) begin
      m_idx  = 0;
      m_word = '0;
    end else if (m_idx < 100) begin
      m_idx++;
    end
    m_prev = daclrck;
    if (m_idx >= 1 && m_idx <= DW) m_word[DW-m_idx] = dacdat;
    if (m_idx == DW && dac_chk) begin
      if (dac_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dac_word: got %h, expected no checked slot", m_word);
      end else begin
        check("dac_word", m_word, dac_exp.pop_front());
      end
    end
  end

  task automatic do_read();
    @(posedge ck); #1; read = 1'b1;
    @(posedge ck); #1; read = 1'b0;
  endtask

  task automatic do_write(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(posedge ck); #1; write = 1'b1; wl = l; wr = r;
    @(posedge ck); #1; write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ck); rst = 1'b1;
    adc_exp.delete();
    dac_exp.delete();
    repeat (2) @(negedge ck);
    rst = 1'b0;
    repeat (5) @(negedge ck);
  endtask

  // mode 0 plain, 1 time read_ready after right LSB, 2 read at the push cycle,
  // 3 reset mid left word and abandon the frame
  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int mode);
    @(negedge ck);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < SLOT; i++) begin
        bclk = 1'b0;
        if (i == 0) begin
          adclrck = (s == 1);
          daclrck = (s == 1);
        end
        adcdat = (i >= 1 && i <= DW) ? ((s == 0) ? l[DW-i] : r[DW-i]) : 1'b0;
        #HB;
        bclk = 1'b1;
        if (mode == 3 && s == 0 && i == 10) begin
          rst = 1'b1;
          #20;
          check_all_zero("midframe_rst");
          #10;
          rst = 1'b0;
          #HB;
          adclrck = 1'b1;
          daclrck = 1'b1;
          #(4*HB);
          return;
        end
        if (s == 1 && i == DW && mode == 1) begin
          #10;
          check("read_ready_before_push", read_ready, 0);
          #30;
          check("read_ready_4ck", read_ready, 1);
          #(HB-40);
        end else if (s == 1 && i == DW && mode == 2) begin
          #26; read = 1'b1;
          #10; read = 1'b0;
          #(HB-36);
        end else begin
          #HB;
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge ck);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge ck); #1;
    check("write_ready_first_edge", write_ready, 1);
    do_read();
    check("read_empty_ignored", read_ready, 0);

    // single ADC frame
    adc_exp.push_back({24'hA5A5A5, 24'h123456});
    frame(24'hA5A5A5, 24'h123456, 1);
    do_read();
    check("adc_empty_after_read", read_ready, 0);

    // DAC playback of two pairs then underflow
    do_reset();
    do_write(24'h000001, 24'h000002);
    do_write(24'h000003, 24'h000004);
    dac_exp.push_back(24'h000001); dac_exp.push_back(24'h000002);
    dac_exp.push_back(24'h000003); dac_exp.push_back(24'h000004);
    dac_exp.push_back(24'h000000); dac_exp.push_back(24'h000000);
    dac_chk = 1'b1;
    frame('0, '0, 0);
    frame('0, '0, 0);
    check("dac_underflow_not_yet", dac_underflow, 0);
    frame('0, '0, 0);
    dac_chk = 1'b0;
    check("dac_underflow_set", dac_underflow, 1);

    // DAC FIFO full handling
    do_reset();
    do_write(24'h000011, 24'h000012);
    do_write(24'h000021, 24'h000022);
    do_write(24'h000031, 24'h000032);
    check("write_ready_3", write_ready, 1);
    do_write(24'h000041, 24'h000042);
    check("write_ready_full", write_ready, 0);
    do_write(24'h000051, 24'h000052);
    check("write_ready_still_full", write_ready, 0);
    dac_exp.push_back(24'h000011); dac_exp.push_back(24'h000012);
    dac_exp.push_back(24'h000021); dac_exp.push_back(24'h000022);
    dac_exp.push_back(24'h000031); dac_exp.push_back(24'h000032);
    dac_exp.push_back(24'h000041); dac_exp.push_back(24'h000042);
    dac_chk = 1'b1;
    frame('0, '0, 0);
    check("write_ready_after_pop", write_ready, 1);
    frame('0, '0, 0);
    frame('0, '0, 0);
    frame('0, '0, 0);
    dac_chk = 1'b0;
    check("dac_no_underflow_4", dac_underflow, 0);

    // ADC overflow: fifth frame dropped
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) adc_exp.push_back({tl[k], tr[k]});
      if (k == 4) check("adc_overflow_at_full", adc_overflow, 0);
      frame(tl[k], tr[k], 0);
    end
    check("adc_overflow_set", adc_overflow, 1);
    check("adc_ready_overflow", read_ready, 1);
    for (int k = 0; k < 4; k++) do_read();
    check("adc_drained", read_ready, 0);

    // ADC full, push coincides with a pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      adc_exp.push_back({tl[k], tr[k]});
      frame(tl[k], tr[k], 0);
    end
    adc_exp.push_back({tl[4], tr[4]});
    frame(tl[4], tr[4], 2);
    check("adc_overflow_pushpop", adc_overflow, 0);
    for (int k = 0; k < 4; k++) do_read();
    check("adc_occupancy_4", read_ready, 0);

    // reset in the middle of a left word
    do_reset();
    frame(24'h111111, 24'h222222, 0);
    check("pre_rst_read_ready", read_ready, 1);
    check("pre_rst_underflow", dac_underflow, 1);
    frame(24'h333333, 24'h444444, 3);
    adc_exp.push_back({24'hC3C3C3, 24'h0000FF});
    frame(24'hC3C3C3, 24'h0000FF, 0);
    do_read();
    check("post_rst_single_pair", read_ready, 0);

    check("adc_queue_drained", adc_exp.size(), 0);
    check("dac_queue_drained", dac_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
